cache_sram_ctrl: RTL

// - Initiator for the single-port cache SRAM macro (1RW; active-low CSB/WEB/OEB; sync read).
// - Turns a valid/ready request port into registered SRAM strobes and returns read data via a

---
 rtl/cache_sram_ctrl.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/cache_sram_ctrl.sv
// cache_sram_ctrl: initiator for a single-port (1RW) synchronous-read cache SRAM.
// Accepts valid/ready requests, drives registered active-low SRAM strobes, and
// returns read data through a 2-entry response FIFO. After reset, or when a
// flush is requested, it writes InitValue to every line before serving requests.
module cache_sram_ctrl #(
  parameter int                DWidth    = 56,
  parameter int                Depth     = 128,
  parameter logic [DWidth-1:0] InitValue = '0,
  localparam int               Index     = $clog2(Depth)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  output logic              init_done_o,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [Index-1:0]  req_addr_i,
  input  logic [DWidth-1:0] req_wdata_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DWidth-1:0] rsp_rdata_o,
  output logic              sram_csb_o,
  output logic              sram_web_o,
  output logic              sram_oeb_o,
  output logic [Index-1:0]  sram_addr_o,
  output logic [DWidth-1:0] sram_data_o,
  input  logic [DWidth-1:0] sram_data_i
);

  localparam logic [0:0]       ST_INIT  = 1'b0;
  localparam logic [0:0]       ST_IDLE  = 1'b1;
  localparam logic [Index-1:0] LastLine = Index'(Depth - 1);

  // Control state
  logic [0:0]        r_state;
  logic [Index-1:0]  r_ptr;
  logic              r_flush_pend;
  // Read pipeline: r_rd_s1 = strobe on the pins, r_rd_s2 = data on sram_data_i
  logic              r_rd_s1;
  logic              r_rd_s2;

  // Registered SRAM pins
  logic              r_sram_csb;
  logic              r_sram_web;
  logic              r_sram_oeb;
  logic [Index-1:0]  r_sram_addr;
  logic [DWidth-1:0] r_sram_data;

  // Response FIFO
  logic [DWidth-1:0] r_fifo_mem [2];
  logic              r_fifo_wr;
  logic              r_fifo_rd;
  logic [1:0]        r_fifo_cnt;

  logic              w_init_done;
  logic              w_rsp_valid;
  logic              w_pop;
  logic              w_push;
  logic              w_req_fire;
  logic              w_drained;
  logic [2:0]        w_outstanding;

  assign w_init_done = (r_state == ST_IDLE);
  assign w_rsp_valid = (r_fifo_cnt != 2'd0);
  assign w_pop       = w_rsp_valid & rsp_ready_i;
  assign w_push      = r_rd_s2;
  assign w_drained   = ~r_rd_s1 & ~r_rd_s2 & (r_fifo_cnt == 2'd0);

  // Every accepted read eventually needs a FIFO slot, so reads still in the
  // pipeline count against the two entries. A pop this cycle frees one slot
  // early, which is why ready depends combinationally on rsp_ready_i.
  assign w_outstanding = 3'(r_rd_s1) + 3'(r_rd_s2) + 3'(r_fifo_cnt) - 3'(w_pop);
  assign req_ready_o   = w_init_done & ~r_flush_pend & (w_outstanding < 3'd2);
  assign w_req_fire    = req_valid_i & req_ready_o;

  // Sweep/request sequencing and registered SRAM strobes.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= ST_INIT;
      r_ptr        <= '0;
      r_flush_pend <= 1'b0;
      r_rd_s1      <= 1'b0;
      r_rd_s2      <= 1'b0;
      r_sram_csb   <= 1'b1;
      r_sram_web   <= 1'b1;
      r_sram_oeb   <= 1'b1;
      r_sram_addr  <= '0;
      r_sram_data  <= '0;
    end else begin
      // NOTE: non-blocking assignments let the defaults below be overridden
      // later in the block while every right-hand side still reads the
      // pre-edge value, so the read pipeline shifts correctly.
      r_sram_csb <= 1'b1;
      r_sram_web <= 1'b1;
      r_sram_oeb <= ~r_rd_s1;
      r_rd_s2    <= r_rd_s1;
      r_rd_s1    <= 1'b0;

      case (r_state)
        ST_INIT: begin
          r_sram_csb  <= 1'b0;
          r_sram_web  <= 1'b0;
          r_sram_addr <= r_ptr;
          r_sram_data <= InitValue;
          r_ptr       <= r_ptr + Index'(1);
          if (r_ptr == LastLine) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          if (w_req_fire) begin
            r_sram_csb  <= 1'b0;
            r_sram_web  <= ~req_we_i;
            r_sram_addr <= req_addr_i;
            r_sram_data <= req_wdata_i;
            r_rd_s1     <= ~req_we_i;
          end
          // A flush waits until every accepted read has been handed back.
          if (r_flush_pend) begin
            if (w_drained) begin
              r_state      <= ST_INIT;
              r_ptr        <= '0;
              r_flush_pend <= 1'b0;
            end
          end else if (flush_i) begin
            r_flush_pend <= 1'b1;
          end
        end
      endcase
    end
  end

  // Response FIFO: capture read data one cycle after the strobe, pop on handshake.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      // NOTE: the two storage words are reset only because the head drives
      // rsp_rdata_o directly and must read zero out of reset.
      for (int i = 0; i < 2; i++) begin
        r_fifo_mem[i] <= '0;
      end
      r_fifo_wr  <= 1'b0;
      r_fifo_rd  <= 1'b0;
      r_fifo_cnt <= 2'd0;
    end else begin
      if (w_push) begin
        r_fifo_mem[r_fifo_wr] <= sram_data_i;
        r_fifo_wr             <= ~r_fifo_wr;
      end
      if (w_pop) begin
        r_fifo_rd <= ~r_fifo_rd;
      end
      r_fifo_cnt <= r_fifo_cnt + 2'(w_push) - 2'(w_pop);
    end
  end

  assign init_done_o = w_init_done;
  assign rsp_valid_o = w_rsp_valid;
  assign rsp_rdata_o = r_fifo_mem[r_fifo_rd];
  assign sram_csb_o  = r_sram_csb;
  assign sram_web_o  = r_sram_web;
  assign sram_oeb_o  = r_sram_oeb;
  assign sram_addr_o = r_sram_addr;
  assign sram_data_o = r_sram_data;

endmodule
